// File: rtl/bp_pkg.sv
// Shared definitions for the branch target predictor: direction-counter
// encoding, default address width and the default-configuration entry layout.
package bp_pkg;

  localparam int BP_ADDR_W  = 16;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                          valid;
    logic [BP_ADDR_W-BP_IDX_W-1:0] tag;
    logic [BP_ADDR_W-1:0]          target;
    logic [1:0]                    ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != CTR_ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!taken_i && (ctr_i != CTR_SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters; combinational
// lookup on registered state, training from the execute-stage update port.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = BP_ADDR_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] next_program_counter_if_to_bp,
  output logic [ADDR_W-1:0] target_bp,
  output logic              target_en_bp,
  input  logic              update_en_ex,
  input  logic [ADDR_W-1:0] update_pc_ex,
  input  logic              update_taken_ex,
  input  logic [ADDR_W-1:0] update_target_ex,
  output logic [15:0]       hit_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [15:0]        hit_count_q, hit_count_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       ctr_step;
  logic [1:0]       ctr_d;
  logic             ctr_we;
  logic             entry_we;

  assign lk_idx = next_program_counter_if_to_bp[IDX_W-1:0];
  assign lk_tag = next_program_counter_if_to_bp[ADDR_W-1:IDX_W];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign target_en_bp = !reset && lk_hit && (ctr_q[lk_idx] >= CTR_WT);
  assign target_bp    = target_en_bp ? target_q[lk_idx] : '0;

  assign up_idx = update_pc_ex[IDX_W-1:0];
  assign up_tag = update_pc_ex[ADDR_W-1:IDX_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (update_taken_ex),
    .ctr_o   (ctr_step)
  );

  // A miss that resolves taken (re)allocates the entry as weakly taken;
  // a miss that resolves not-taken leaves the entry alone.
  assign ctr_d    = up_hit ? ctr_step : CTR_WT;
  assign ctr_we   = update_en_ex && (up_hit || update_taken_ex);
  assign entry_we = update_en_ex && update_taken_ex;

  assign hit_count_d = hit_count_q + {15'd0, target_en_bp};
  assign hit_count   = hit_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      hit_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_SNT;
      end
    end else begin
      hit_count_q <= hit_count_d;
      if (ctr_we) begin
        ctr_q[up_idx] <= ctr_d;
      end
      if (entry_we) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  // Tag/target need no reset: they are masked by valid until rewritten.
  always_ff @(posedge clk) begin
    if (!reset && entry_we) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= update_target_ex;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] next_pc;
  logic [15:0] target_bp;
  logic        target_en_bp;
  logic        update_en_ex;
  logic [15:0] update_pc_ex;
  logic        update_taken_ex;
  logic [15:0] update_target_ex;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] IDLE_PC = 16'h0040;

  branch_target_predictor #(.ENTRIES(16), .ADDR_W(16)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .next_program_counter_if_to_bp (next_pc),
    .target_bp                     (target_bp),
    .target_en_bp                  (target_en_bp),
    .update_en_ex                  (update_en_ex),
    .update_pc_ex                  (update_pc_ex),
    .update_taken_ex               (update_taken_ex),
    .update_target_ex              (update_target_ex),
    .hit_count                     (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One resolved-branch update, presented for exactly one rising edge.
  task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    update_en_ex     = 1'b1;
    update_pc_ex     = pc;
    update_taken_ex  = taken;
    update_target_ex = tgt;
    tick();
    update_en_ex = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    next_pc = 16'h0013;
    #1;
    checks++;
    if (target_en_bp !== 1'b0 || target_bp !== 16'h0000 || hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: en=%0b tgt=%h cnt=%h, expected en=0 tgt=0000 cnt=0000",
               target_en_bp, target_bp, hit_count);
    end
    next_pc = IDLE_PC;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (target_en_bp !== 1'b0 || target_bp !== 16'h0000) begin
        errors++;
        $display("FAIL idle_lookup[%0d]: en=%0b tgt=%h, expected en=0 tgt=0000",
                 i, target_en_bp, target_bp);
      end
    end
    checks++;
    if (hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL idle_hit_count: got %h, expected 0000", hit_count);
    end
  endtask

  task automatic test_allocate();
    next_pc          = 16'h0013;
    update_en_ex     = 1'b1;
    update_pc_ex     = 16'h0013;
    update_taken_ex  = 1'b1;
    update_target_ex = 16'h0100;
    #1;
    checks++;
    if (target_en_bp !== 1'b0 || target_bp !== 16'h0000) begin
      errors++;
      $display("FAIL alloc_same_cycle: en=%0b tgt=%h, expected en=0 tgt=0000",
               target_en_bp, target_bp);
    end
    tick();
    update_en_ex = 1'b0;
    checks++;
    if (target_en_bp !== 1'b1 || target_bp !== 16'h0100) begin
      errors++;
      $display("FAIL alloc_next_cycle: en=%0b tgt=%h, expected en=1 tgt=0100",
               target_en_bp, target_bp);
    end
    next_pc = IDLE_PC;
  endtask

  task automatic test_hysteresis();
    logic [15:0] pcs  [4] = '{16'h0013, 16'h0013, 16'h0013, 16'h0013};
    logic        tkn  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] tgts [4] = '{16'h0999, 16'h0888, 16'h0150, 16'h0160};
    logic        e_en [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] e_tg [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0160};
    for (int i = 0; i < 4; i++) begin
      upd(pcs[i], tkn[i], tgts[i]);
      next_pc = 16'h0013;
      #1;
      checks++;
      if (target_en_bp !== e_en[i] || target_bp !== e_tg[i]) begin
        errors++;
        $display("FAIL hysteresis[%0d]: en=%0b tgt=%h, expected en=%0b tgt=%h",
                 i, target_en_bp, target_bp, e_en[i], e_tg[i]);
      end
      next_pc = IDLE_PC;
    end
  endtask

  task automatic test_saturation();
    // Counter starts at 2: taken steps 3,3,3,3,3; not-taken steps 2,1,0,0,0;
    // then taken steps 1,2.
    logic        tkn  [12] = '{1,1,1,1,1, 0,0,0,0,0, 1,1};
    logic [15:0] tgts [12] = '{16'h0170, 16'h0171, 16'h0172, 16'h0173, 16'h0174,
                               16'h0aaa, 16'h0aaa, 16'h0aaa, 16'h0aaa, 16'h0aaa,
                               16'h0180, 16'h0181};
    logic        e_en [12] = '{1,1,1,1,1, 1,0,0,0,0, 0,1};
    logic [15:0] e_tg [12] = '{16'h0170, 16'h0171, 16'h0172, 16'h0173, 16'h0174,
                               16'h0174, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0181};
    for (int i = 0; i < 12; i++) begin
      upd(16'h0013, tkn[i], tgts[i]);
      next_pc = 16'h0013;
      #1;
      checks++;
      if (target_en_bp !== e_en[i] || target_bp !== e_tg[i]) begin
        errors++;
        $display("FAIL saturation[%0d]: en=%0b tgt=%h, expected en=%0b tgt=%h",
                 i, target_en_bp, target_bp, e_en[i], e_tg[i]);
      end
      next_pc = IDLE_PC;
    end
  endtask

  task automatic test_alias();
    // Index 3 holds 0x0013 with ctr=2; step through replace by 0x0023.
    logic [15:0] u_pc [5] = '{16'h0013, 16'h0023, 16'h0033, 16'h0023, 16'h0023};
    logic        u_tk [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] u_tg [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0bbb, 16'h0210};
    // Lookups after each update: 0x0013, 0x0023, 0x0033.
    logic        e_en [5][3] = '{'{1,0,0}, '{0,1,0}, '{0,1,0}, '{0,0,0}, '{0,1,0}};
    logic [15:0] e_tg [5][3] = '{'{16'h0100, 16'h0000, 16'h0000},
                                 '{16'h0000, 16'h0200, 16'h0000},
                                 '{16'h0000, 16'h0200, 16'h0000},
                                 '{16'h0000, 16'h0000, 16'h0000},
                                 '{16'h0000, 16'h0210, 16'h0000}};
    logic [15:0] lk   [3] = '{16'h0013, 16'h0023, 16'h0033};
    for (int i = 0; i < 5; i++) begin
      upd(u_pc[i], u_tk[i], u_tg[i]);
      for (int j = 0; j < 3; j++) begin
        next_pc = lk[j];
        #1;
        checks++;
        if (target_en_bp !== e_en[i][j] || target_bp !== e_tg[i][j]) begin
          errors++;
          $display("FAIL alias[%0d] pc=%h: en=%0b tgt=%h, expected en=%0b tgt=%h",
                   i, lk[j], target_en_bp, target_bp, e_en[i][j], e_tg[i][j]);
        end
      end
      next_pc = IDLE_PC;
    end
  endtask

  task automatic test_hit_count();
    checks++;
    if (hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL hit_count_start: got %h, expected 0000", hit_count);
    end
    next_pc = 16'h0023;
    repeat (7) tick();
    checks++;
    if (hit_count !== 16'd7) begin
      errors++;
      $display("FAIL hit_count_7: got %h, expected 0007", hit_count);
    end
    next_pc = IDLE_PC;
    repeat (3) tick();
    checks++;
    if (hit_count !== 16'd7) begin
      errors++;
      $display("FAIL hit_count_hold: got %h, expected 0007", hit_count);
    end
    next_pc = 16'h0023;
    repeat (65528) @(posedge clk);
    #1;
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL hit_count_max: got %h, expected ffff", hit_count);
    end
    tick();
    checks++;
    if (hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL hit_count_wrap: got %h, expected 0000", hit_count);
    end
    next_pc = IDLE_PC;
  endtask

  task automatic test_async_reset();
    logic [15:0] lk [3] = '{16'h0023, 16'h0015, 16'h0013};
    upd(16'h0015, 1'b1, 16'h0500);
    next_pc          = 16'h0023;
    update_en_ex     = 1'b1;
    update_pc_ex     = 16'h0023;
    update_taken_ex  = 1'b1;
    update_target_ex = 16'h0222;
    #1;
    checks++;
    if (target_en_bp !== 1'b1 || target_bp !== 16'h0210) begin
      errors++;
      $display("FAIL pre_reset: en=%0b tgt=%h, expected en=1 tgt=0210",
               target_en_bp, target_bp);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (target_en_bp !== 1'b0 || target_bp !== 16'h0000 || hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_immediate: en=%0b tgt=%h cnt=%h, expected en=0 tgt=0000 cnt=0000",
               target_en_bp, target_bp, hit_count);
    end
    tick();
    checks++;
    if (target_en_bp !== 1'b0 || target_bp !== 16'h0000 || hit_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_held_edge: en=%0b tgt=%h cnt=%h, expected en=0 tgt=0000 cnt=0000",
               target_en_bp, target_bp, hit_count);
    end
    update_en_ex = 1'b0;
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      next_pc = lk[j];
      #1;
      checks++;
      if (target_en_bp !== 1'b0 || target_bp !== 16'h0000) begin
        errors++;
        $display("FAIL post_reset pc=%h: en=%0b tgt=%h, expected en=0 tgt=0000",
                 lk[j], target_en_bp, target_bp);
      end
    end
    next_pc = 16'h0023;
    repeat (3) tick();
    checks++;
    if (hit_count !== 16'h0000 || target_en_bp !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_count: cnt=%h en=%0b, expected cnt=0000 en=0",
               hit_count, target_en_bp);
    end
    next_pc = IDLE_PC;
  endtask

  initial begin
    reset            = 1'b1;
    next_pc          = IDLE_PC;
    update_en_ex     = 1'b0;
    update_pc_ex     = 16'h0000;
    update_taken_ex  = 1'b0;
    update_target_ex = 16'h0000;

    test_reset();
    test_allocate();
    test_hysteresis();
    test_saturation();
    test_alias();
    test_hit_count();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Predictor that answers the fetch stage's per-cycle prediction request.
- Fetch presents the PC it will fetch next. The predictor returns a redirect target and enable in the same cycle; this is a combinational lookup on registered state.
- Learns from resolved branches through an update port driven by the execute stage.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- ADDR_W, 16, PC and target width in words.
- IDX_W, log2(ENTRIES), index width; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all entries.
- next_program_counter_if_to_bp  input  ADDR_W  lookup PC from the fetch stage.
- target_bp  output  ADDR_W  predicted target for the lookup PC.
- target_en_bp  output  1  1 = fetch redirects to target_bp.
- update_en_ex  input  1  a branch resolved this cycle.
- update_pc_ex  input  ADDR_W  address of the resolved branch.
- update_taken_ex  input  1  actual direction.
- update_target_ex  input  ADDR_W  actual taken target.
- hit_count  output  16  number of cycles in which target_en_bp was 1; wraps at 2^16.

Behaviour:
- Entry fields: valid (1), tag (ADDR_W-IDX_W), target (ADDR_W), ctr (2).
  - Index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
- Reset (asynchronous, any time, including mid-update):
  - All valid bits = 0, all ctr = 0, hit_count = 0.
  - target_bp = 0 and target_en_bp = 0 for as long as reset is high.
  - Tag and target storage may keep stale contents; it is never observed while valid = 0.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] && tag[idx] == lookup tag.
  - target_en_bp = hit && ctr[idx] >= 2.
  - target_bp = target[idx] when target_en_bp = 1, else 0.
  - No combinational path from the update_* ports to the outputs.
- Update (rising clk edge when update_en_ex = 1 and reset = 0):
  - Hit, taken: ctr saturating increment (max 3); target <= update_target_ex.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged; entry stays valid.
  - Miss, taken: allocate or replace the entry: valid = 1, tag, target, ctr = 2 (weakly taken).
  - Miss, not taken: no change.
- Simultaneous lookup and update to the same index:
  - Lookup sees the pre-edge contents (read-before-write).
  - The new contents are visible from the next cycle.
- Counter encoding: 0 strong not-taken, 1 weak not-taken, 2 weak taken, 3 strong taken.
- hit_count increments at each clk edge where target_en_bp = 1; wraps from 16'hFFFF to 0.
- Address arithmetic: none. Target wrap-around is the caller's concern; stored values are verbatim.

Decomposition:
- Shared package (bp_pkg):
  - Counter encoding constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - Default ADDR_W.
  - Entry struct typedef.
- Natural sub-module: sat_counter2, a pure next-state function. Inputs: current ctr and taken. Output: next ctr. Instantiated once in the update path.
- Storage stays in the top module as flop arrays; an SRAM macro is not permitted because lookup is asynchronous.

Test Plan:
- Reset then idle: lookup 16'h0040 for 10 cycles -> target_en_bp = 0, target_bp = 0, hit_count = 0.
- Allocate:
  - Stimulus: update pc = 16'h0013, taken, target = 16'h0100; next cycle look up 16'h0013.
  - Required: target_en_bp = 1, target_bp = 16'h0100; the same-cycle lookup during the update edge returns 0.
- Hysteresis:
  - Stimulus: starting from ctr = 2 at 16'h0013, apply one not-taken update; then a second not-taken update; then two taken updates.
  - Required: after the first not-taken, ctr = 1 and the prediction drops. After the second, ctr = 0. After the two taken, ctr = 2 and the prediction returns with the last target.
- Saturation: 5 taken updates on 16'h0013 -> ctr = 3; 5 not-taken -> ctr = 0; no wrap observed.
- Alias/replace:
  - Stimulus: allocate 16'h0013 to 16'h0100; then a taken update for 16'h0023 (same index 3) to 16'h0200.
  - Required: lookup 16'h0013 misses; lookup 16'h0023 gives 16'h0200 with ctr = 2.
  - A not-taken update for 16'h0033 changes nothing.
- Asynchronous reset mid-stream: assert reset between clk edges while entries are valid and update_en_ex = 1 -> outputs drop to 0 immediately; after release all lookups miss and hit_count = 0.
